// File: rtl/pico_bus_pkg.sv
// Shared types and helpers for the picorv32 native-bus decoder.
// Holds the FSM state encoding, the default error read pattern and region extraction.
package pico_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } bus_state_t;

  localparam logic [31:0] DEFAULT_ERROR_RDATA = 32'hDEAD_BEEF;

  // Returns addr[msb:lsb] right-aligned; the mask wraps to all-ones for a 32-bit field.
  function automatic logic [31:0] region_of(input logic [31:0] addr,
                                            input int          msb,
                                            input int          lsb);
    logic [31:0] mask;
    mask = (32'h1 << (msb - lsb + 1)) - 32'h1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/pico_bus_addr_decode.sv
// Combinational priority decoder: region field -> one-hot hit, slave index and miss flag.
// When several slaves claim the same region the lowest index wins.
module pico_bus_addr_decode
  import pico_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES    = 4,
  parameter int                       RW            = 4,
  parameter int                       IDX_W         = 2,
  parameter logic [NUM_SLAVES*RW-1:0] SLAVE_REGIONS = {4'h3, 4'h2, 4'h1, 4'h0}
) (
  input  logic [RW-1:0]         region,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [IDX_W-1:0]      index,
  output logic                  miss
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    hit   = '0;
    index = '0;
    miss  = 1'b1;
    // Scan from the top down so the last (lowest-index) match overrides the rest.
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (region == SLAVE_REGIONS[k*RW +: RW]) begin
        hit    = '0;
        hit[k] = 1'b1;
        index  = IDX_W'(k);
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pico_bus_decoder.sv
// Address decoder/interconnect between the picorv32 native memory port and NUM_SLAVES slaves,
// with registered slave requests, per-access timeout and error status capture.
module pico_bus_decoder
  import pico_bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int DECODE_MSB     = 31,
  parameter int DECODE_LSB     = 28,
  parameter logic [NUM_SLAVES*(DECODE_MSB-DECODE_LSB+1)-1:0] SLAVE_REGIONS =
    {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_RDATA = DEFAULT_ERROR_RDATA
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     m_valid,
  input  logic                     m_instr,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_instr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     bus_error,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int RW    = DECODE_MSB - DECODE_LSB + 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  bus_state_t             state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [NUM_SLAVES-1:0]  s_valid_q, s_valid_d;
  logic                   s_instr_q, s_instr_d;
  logic [31:0]            s_addr_q, s_addr_d;
  logic [31:0]            s_wdata_q, s_wdata_d;
  logic [3:0]             s_wstrb_q, s_wstrb_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [31:0]            m_rdata_q, m_rdata_d;
  logic                   bus_error_q, bus_error_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [7:0]             err_count_q, err_count_d;

  logic [RW-1:0]          region;
  logic [NUM_SLAVES-1:0]  dec_hit;
  logic [IDX_W-1:0]       dec_index;
  logic                   dec_miss;
  logic                   sel_ready;
  logic [31:0]            sel_rdata;
  logic                   timeout_hit;

  assign region = RW'(region_of(m_addr, DECODE_MSB, DECODE_LSB));

  pico_bus_addr_decode #(
    .NUM_SLAVES    (NUM_SLAVES),
    .RW            (RW),
    .IDX_W         (IDX_W),
    .SLAVE_REGIONS (SLAVE_REGIONS)
  ) u_addr_decode (
    .region (region),
    .hit    (dec_hit),
    .index  (dec_index),
    .miss   (dec_miss)
  );

  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[32*int'(sel_q) +: 32];

  // The cycle that would bring the wait count up to TIMEOUT_CYCLES is the last one allowed.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    s_valid_d   = s_valid_q;
    s_instr_d   = s_instr_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    cnt_d       = cnt_q;
    m_rdata_d   = m_rdata_q;
    bus_error_d = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          if (!dec_miss) begin
            sel_d     = dec_index;
            s_valid_d = dec_hit;
            s_instr_d = m_instr;
            s_addr_d  = m_addr;
            s_wdata_d = m_wdata;
            s_wstrb_d = m_wstrb;
            cnt_d     = '0;
            state_d   = ACCESS;
          end else begin
            m_rdata_d   = ERROR_RDATA;
            bus_error_d = 1'b1;
            err_addr_d  = m_addr;
            err_count_d = sat_inc(err_count_q);
            state_d     = RESPOND;
          end
        end
      end

      ACCESS: begin
        // A ready on the timeout cycle still wins over the error path.
        if (sel_ready) begin
          s_valid_d = '0;
          m_rdata_d = (s_wstrb_q == 4'b0000) ? sel_rdata : 32'h0;
          state_d   = RESPOND;
        end else if (timeout_hit) begin
          s_valid_d   = '0;
          m_rdata_d   = ERROR_RDATA;
          bus_error_d = 1'b1;
          err_addr_d  = s_addr_q;
          err_count_d = sat_inc(err_count_q);
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESPOND: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking assignments.
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      s_valid_q   <= '0;
      s_instr_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      cnt_q       <= '0;
      m_rdata_q   <= '0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      s_valid_q   <= s_valid_d;
      s_instr_q   <= s_instr_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      cnt_q       <= cnt_d;
      m_rdata_q   <= m_rdata_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign m_ready   = (state_q == RESPOND);
  assign m_rdata   = m_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_instr   = s_instr_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign bus_error = bus_error_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_pico_bus_decoder.sv
// Self-checking bench for pico_bus_decoder: directed scenarios plus random traffic
// scored against a transaction-level model of decode, latency, timeout and error status.
module tb_pico_bus_decoder;

  localparam int          TMO     = 8;
  localparam logic [15:0] REGIONS = {4'h3, 4'h2, 4'h1, 4'h0};
  localparam logic [15:0] OVL_REG = {4'h3, 4'h2, 4'h1, 4'h2};
  localparam logic [31:0] ERR_RD  = 32'hDEAD_BEEF;

  logic         clock = 1'b0;
  logic         reset;

  logic         m_valid, m_instr;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic         s_instr;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         bus_error;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  logic         m_valid_o, m_instr_o;
  logic [31:0]  m_addr_o, m_wdata_o;
  logic [3:0]   m_wstrb_o;
  logic         m_ready_o;
  logic [31:0]  m_rdata_o;
  logic [3:0]   s_valid_o;
  logic         s_instr_o;
  logic [31:0]  s_addr_o, s_wdata_o;
  logic [3:0]   s_wstrb_o;
  logic [3:0]   s_ready_o;
  logic [127:0] s_rdata_o;
  logic         bus_error_o;
  logic [31:0]  err_addr_o;
  logic [7:0]   err_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err_count = 0;

  always #5 clock = ~clock;

  pico_bus_decoder #(
    .NUM_SLAVES(4), .DECODE_MSB(31), .DECODE_LSB(28), .SLAVE_REGIONS(REGIONS),
    .TIMEOUT_CYCLES(TMO), .ERROR_RDATA(ERR_RD)
  ) dut (
    .clock(clock), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_error(bus_error), .err_addr(err_addr), .err_count(err_count)
  );

  pico_bus_decoder #(
    .NUM_SLAVES(4), .DECODE_MSB(31), .DECODE_LSB(28), .SLAVE_REGIONS(OVL_REG),
    .TIMEOUT_CYCLES(255), .ERROR_RDATA(ERR_RD)
  ) dut_ovl (
    .clock(clock), .reset(reset),
    .m_valid(m_valid_o), .m_instr(m_instr_o), .m_addr(m_addr_o), .m_wdata(m_wdata_o),
    .m_wstrb(m_wstrb_o), .m_ready(m_ready_o), .m_rdata(m_rdata_o),
    .s_valid(s_valid_o), .s_instr(s_instr_o), .s_addr(s_addr_o), .s_wdata(s_wdata_o),
    .s_wstrb(s_wstrb_o), .s_ready(s_ready_o), .s_rdata(s_rdata_o),
    .bus_error(bus_error_o), .err_addr(err_addr_o), .err_count(err_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which slave owns an address under a region table: lowest-numbered match, -1 for none.
  function automatic int owner(input logic [31:0] addr, input logic [15:0] regions);
    for (int k = 0; k < 4; k++)
      if (addr[31:28] == regions[k*4 +: 4]) return k;
    return -1;
  endfunction

  // One master transaction on the main DUT, called right after a falling edge.
  // waits < 0 means the slave never answers.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input logic instr, input int waits,
                         input logic [31:0] rdat);
    int          k, lat, exp_vcyc, cyc, vcyc;
    bit          err, done;
    logic [31:0] exp_rd;
    logic [3:0]  exp_oh;

    k        = owner(addr, REGIONS);
    err      = (k < 0) || (waits < 0) || (waits >= TMO);
    lat      = (k < 0) ? 1 : (err ? TMO + 1 : waits + 2);
    exp_vcyc = (k < 0) ? 0 : (err ? TMO : waits + 1);
    exp_rd   = err ? ERR_RD : ((wstrb != 4'b0000) ? 32'h0 : rdat);
    exp_oh   = (k < 0) ? 4'b0000 : (4'b0001 << k);

    m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata; m_instr = instr;
    cyc = 0; vcyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      s_ready = '0;
      if (s_valid !== 4'b0000) begin
        check({tag, "_s_valid"}, 32'(s_valid), 32'(exp_oh));
        check({tag, "_s_addr"},  s_addr,  addr);
        check({tag, "_s_wdata"}, s_wdata, wdata);
        check({tag, "_s_wstrb"}, 32'(s_wstrb), 32'(wstrb));
        check({tag, "_s_instr"}, 32'(s_instr), 32'(instr));
        if (k >= 0 && waits >= 0 && vcyc == waits) begin
          s_ready[k]          = 1'b1;
          s_rdata[k*32 +: 32] = rdat;
        end
        vcyc++;
      end
      if (m_ready === 1'b1) begin
        done = 1'b1;
        m_valid = 1'b0;
        if (err) exp_err_count = (exp_err_count < 255) ? exp_err_count + 1 : 255;
        check({tag, "_latency"},   32'(cyc),  32'(lat));
        check({tag, "_valid_cyc"}, 32'(vcyc), 32'(exp_vcyc));
        check({tag, "_m_rdata"},   m_rdata, exp_rd);
        check({tag, "_bus_error"}, 32'(bus_error), 32'(err));
        check({tag, "_err_count"}, 32'(err_count), 32'(exp_err_count));
        if (err) check({tag, "_err_addr"}, err_addr, addr);
      end else begin
        check({tag, "_no_err_early"}, 32'(bus_error), 32'd0);
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    m_valid = 1'b0;

    @(negedge clock);
    s_ready = '0;
    check({tag, "_ready_one_cycle"}, 32'(m_ready), 32'd0);
    check({tag, "_err_one_cycle"},   32'(bus_error), 32'd0);
    check({tag, "_rdata_hold"},      m_rdata, exp_rd);
    check({tag, "_s_valid_idle"},    32'(s_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          waits, rsel;
    logic [31:0] a, d, r;
    logic [3:0]  ws;

    reset = 1'b1;
    m_valid = 0; m_instr = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    s_ready = '0; s_rdata = '0;
    m_valid_o = 0; m_instr_o = 0; m_addr_o = 0; m_wdata_o = 0; m_wstrb_o = 0;
    s_ready_o = '0; s_rdata_o = '0;
    repeat (3) @(negedge clock);

    check("rst_m_ready",   32'(m_ready),   32'd0);
    check("rst_m_rdata",   m_rdata,        32'd0);
    check("rst_s_valid",   32'(s_valid),   32'd0);
    check("rst_s_addr",    s_addr,         32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_err_addr",  err_addr,       32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_txn("read_zero_wait", 32'h3000_0004, 4'b0000, 32'h0, 1'b0, 0, 32'h0123_4567);
    run_txn("write_wait3",    32'h1000_0010, 4'b0011, 32'hAABB_CCDD, 1'b0, 3, 32'h5555_AAAA);
    run_txn("miss",           32'h7000_0000, 4'b0000, 32'h0, 1'b0, 0, 32'h0);
    check("miss_err_addr",  err_addr,       32'h7000_0000);
    check("miss_err_count", 32'(err_count), 32'd1);
    run_txn("ready_on_timeout_cycle", 32'h2000_0020, 4'b0000, 32'h0, 1'b1, TMO - 1, 32'h7777_1234);
    run_txn("timeout", 32'h2000_0040, 4'b0000, 32'h0, 1'b0, -1, 32'h0);
    check("timeout_err_addr", err_addr, 32'h2000_0040);

    // A slave that answers after being abandoned must not produce a response.
    s_ready[2] = 1'b1;
    @(negedge clock);
    s_ready = '0;
    check("late_ready_m_ready", 32'(m_ready), 32'd0);
    @(negedge clock);
    check("late_ready_m_ready2", 32'(m_ready), 32'd0);
    check("late_ready_count",    32'(err_count), 32'(exp_err_count));
    run_txn("after_timeout", 32'h0000_0100, 4'b0000, 32'h0, 1'b1, 1, 32'hCAFE_F00D);

    // Overlapping regions: slaves 0 and 2 both claim region 2.
    m_valid_o = 1'b1; m_addr_o = 32'h2000_0008; m_wstrb_o = 4'b0000;
    @(negedge clock);
    check("ovl_s_valid", 32'(s_valid_o), 32'b0001);
    s_ready_o = 4'b0101;
    s_rdata_o[31:0]  = 32'h1111_0000;
    s_rdata_o[95:64] = 32'h2222_0000;
    @(negedge clock);
    s_ready_o = '0; m_valid_o = 1'b0;
    check("ovl_m_ready", 32'(m_ready_o), 32'd1);
    check("ovl_m_rdata", m_rdata_o,      32'h1111_0000);

    for (int i = 0; i < 40; i++) begin
      rsel  = int'($urandom_range(0, 5));
      a     = {4'(rsel), 28'($urandom)};
      d     = $urandom;
      r     = $urandom;
      ws    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      waits = int'($urandom_range(0, 11));
      if (waits == 11) waits = -1;
      run_txn("random", a, ws, d, 1'($urandom), waits, r);
    end

    for (int i = 0; i < 300; i++) begin
      a = {4'($urandom_range(4, 15)), 28'($urandom)};
      run_txn("sat_miss", a, 4'b0000, 32'h0, 1'b0, 0, 32'h0);
    end
    check("sat_err_count", 32'(err_count), 32'd255);

    // Reset while the slave is stalling: the access is dropped without a response.
    m_valid = 1'b1; m_addr = 32'h2000_0000; m_wstrb = 4'b0000;
    repeat (3) @(negedge clock);
    check("rst_mid_s_valid_before", 32'(s_valid), 32'b0100);
    reset = 1'b1;
    @(negedge clock);
    m_valid = 1'b0;
    check("rst_mid_s_valid",   32'(s_valid),   32'd0);
    check("rst_mid_m_ready",   32'(m_ready),   32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    check("rst_mid_m_rdata",   m_rdata,        32'd0);
    reset = 1'b0;
    exp_err_count = 0;
    @(negedge clock);
    check("rst_mid_no_resp", 32'(m_ready), 32'd0);
    run_txn("after_reset", 32'h2000_0004, 4'b0000, 32'h0, 1'b0, 2, 32'h89AB_CDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
